// File: rtl/ctrl_pipe.sv
// Pipelined RV32I control decoder: ID decode -> EX -> MEM chain -> WB with stall, flush and hazard control.
// Optional macro CTRL_FWD_EN adds fwd_a/fwd_b forwarding selects and narrows hazard detection to load-use.
module ctrl_pipe #(
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned RF_ADDR_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [6:0]           id_opcode,
  input  logic [2:0]           id_funct3,
  input  logic [RF_ADDR_W-1:0] id_rd,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 stall_in,
  input  logic                 ex_take_branch,
  output logic                 PC_Mux,
  output logic [1:0]           ALU_Mux,
  output logic                 SE2_Ctrl,
  output logic                 CSRW_Mux,
  output logic [1:0]           Branch_Mux,
  output logic                 flush_out,
  output logic [1:0]           RByteEn_DM,
  output logic [3:0]           WByteEn_DM,
  output logic [1:0]           DM_Mux,
  output logic                 WrEn_RF,
  output logic [1:0]           WD_Mux,
  output logic [RF_ADDR_W-1:0] wb_rd,
  output logic                 hazard_stall
`ifdef CTRL_FWD_EN
  ,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b
`endif
);

  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic                 valid;
    logic                 jump;
    logic                 br;
    logic                 ld;
    logic [1:0]           alu_mux;
    logic                 se2;
    logic                 csrw;
    logic [1:0]           branch_mux;
    logic [1:0]           rbyte;
    logic [3:0]           wbyte;
    logic [1:0]           dm_mux;
    logic                 wren;
    logic [1:0]           wd_mux;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
  } ctrl_t;

  ctrl_t id_dec;
  ctrl_t ex_q;
  ctrl_t mem_q [MEM_STAGES];
  ctrl_t mem_last;
  ctrl_t wb_q;

  logic is_ld, is_st, is_br, is_opi, is_sys, is_auipc, is_lui, is_jalr, is_jal, is_x100011;
  logic pc_mux_int, flush, raw_any, hazard;
  logic unused_wb;

  assign is_ld      = id_opcode == OP_LD;
  assign is_st      = id_opcode == OP_ST;
  assign is_br      = id_opcode == OP_BR;
  assign is_opi     = id_opcode == OP_OPI;
  assign is_sys     = id_opcode == OP_SYS;
  assign is_auipc   = id_opcode == OP_AUIPC;
  assign is_lui     = id_opcode == OP_LUI;
  assign is_jalr    = id_opcode == OP_JALR;
  assign is_jal     = id_opcode == OP_JAL;
  assign is_x100011 = id_opcode[5:0] == 6'b100011;

  always_comb begin
    id_dec            = '0;
    id_dec.valid      = 1'b1;
    id_dec.jump       = is_auipc | is_jalr | is_jal;
    id_dec.br         = is_br;
    id_dec.ld         = is_ld;
    id_dec.alu_mux    = {is_jalr | is_ld | is_opi | is_x100011,
                         (is_opi & (id_funct3[1:0] == 2'b01)) | is_x100011};
    id_dec.se2        = is_br;
    id_dec.csrw       = is_sys & id_funct3[2];
    id_dec.branch_mux = {is_jalr | is_ld | is_jal, is_auipc | is_lui | is_jal};
    id_dec.rbyte      = id_funct3[1:0];
    if (is_st) begin
      case (id_funct3)
        3'd0:    id_dec.wbyte = 4'b0001;
        3'd1:    id_dec.wbyte = 4'b0011;
        3'd2:    id_dec.wbyte = 4'b1111;
        default: id_dec.wbyte = 4'b0000;
      endcase
    end
    id_dec.dm_mux     = {is_ld & ~id_funct3[1],
                         is_ld & ((id_funct3 == 3'b010) | (id_funct3[2:1] == 2'b10))};
    id_dec.wren       = ~is_br & ~is_st;
    id_dec.wd_mux     = {is_auipc, is_lui};
    id_dec.rd         = id_rd;
    id_dec.rs1        = id_rs1;
    id_dec.rs2        = id_rs2;
  end

  function automatic logic raw_hit(input ctrl_t s, input logic [RF_ADDR_W-1:0] a,
                                   input logic [RF_ADDR_W-1:0] b);
    return s.valid & s.wren & (s.rd != '0) & ((s.rd == a) | (s.rd == b));
  endfunction

  assign mem_last = mem_q[MEM_STAGES-1];

  // With forwarding only loads short of the last MEM stage are unresolvable;
  // without it every in-flight writer blocks ID until it has left WB.
  always_comb begin
    raw_any = 1'b0;
`ifdef CTRL_FWD_EN
    raw_any = raw_hit(ex_q, id_rs1, id_rs2) & ex_q.ld;
    for (int unsigned i = 0; i < MEM_STAGES; i++) begin
      if (i + 1 < MEM_STAGES)
        raw_any = raw_any | (raw_hit(mem_q[i], id_rs1, id_rs2) & mem_q[i].ld);
    end
`else
    raw_any = raw_hit(ex_q, id_rs1, id_rs2) | raw_hit(wb_q, id_rs1, id_rs2);
    for (int unsigned i = 0; i < MEM_STAGES; i++)
      raw_any = raw_any | raw_hit(mem_q[i], id_rs1, id_rs2);
`endif
  end

  assign pc_mux_int = ex_q.valid & (ex_q.jump | (ex_q.br & ex_take_branch));
  assign flush      = pc_mux_int & ~stall_in;
  assign hazard     = id_valid & raw_any & ~flush & ~stall_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
      for (int unsigned i = 0; i < MEM_STAGES; i++) mem_q[i] <= '0;
      wb_q <= '0;
    end else if (!stall_in) begin
      ex_q     <= (id_valid & ~flush & ~hazard) ? id_dec : '0;
      mem_q[0] <= ex_q;
      for (int unsigned i = 1; i < MEM_STAGES; i++) mem_q[i] <= mem_q[i-1];
      wb_q     <= mem_last;
    end
  end

  assign id_ready     = ~rst & ~stall_in & ~hazard;
  assign hazard_stall = hazard;
  assign flush_out    = flush;

  assign PC_Mux     = pc_mux_int;
  assign ALU_Mux    = ex_q.valid ? ex_q.alu_mux    : '0;
  assign SE2_Ctrl   = ex_q.valid & ex_q.se2;
  assign CSRW_Mux   = ex_q.valid & ex_q.csrw;
  assign Branch_Mux = ex_q.valid ? ex_q.branch_mux : '0;

  assign RByteEn_DM = mem_last.valid ? mem_last.rbyte  : '0;
  assign WByteEn_DM = mem_last.valid ? mem_last.wbyte  : '0;
  assign DM_Mux     = mem_last.valid ? mem_last.dm_mux : '0;

  assign WrEn_RF    = wb_q.valid & wb_q.wren;
  assign WD_Mux     = wb_q.valid ? wb_q.wd_mux : '0;
  assign wb_rd      = wb_q.valid ? wb_q.rd     : '0;

`ifdef CTRL_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [RF_ADDR_W-1:0] rs, input ctrl_t m,
                                         input ctrl_t w);
    if (m.valid & m.wren & (m.rd != '0) & (m.rd == rs)) return 2'b01;
    if (w.valid & w.wren & (w.rd != '0) & (w.rd == rs)) return 2'b10;
    return 2'b00;
  endfunction

  assign fwd_a = ex_q.valid ? fwd_sel(ex_q.rs1, mem_last, wb_q) : '0;
  assign fwd_b = ex_q.valid ? fwd_sel(ex_q.rs2, mem_last, wb_q) : '0;
`endif

  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus random traffic against an instruction-level model.
module tb_ctrl_pipe;
  localparam int unsigned MS = 1;
  localparam bit [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011, OPI = 7'b0010011;
  localparam bit [6:0] SYS = 7'b1110011, OPR = 7'b0110011, AUIPC = 7'b0010111, LUI = 7'b0110111;
  localparam bit [6:0] JALR = 7'b1100111, JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst, id_valid, stall_in, ex_take_branch;
  logic [6:0] id_opcode;
  logic [2:0] id_funct3;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       id_ready, PC_Mux, SE2_Ctrl, CSRW_Mux, flush_out, WrEn_RF, hazard_stall;
  logic [1:0] ALU_Mux, Branch_Mux, RByteEn_DM, DM_Mux, WD_Mux;
  logic [3:0] WByteEn_DM;
  logic [4:0] wb_rd;
`ifdef CTRL_FWD_EN
  logic [1:0] fwd_a, fwd_b;
`endif

  ctrl_pipe #(.MEM_STAGES(MS), .RF_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .stall_in(stall_in), .ex_take_branch(ex_take_branch),
    .PC_Mux(PC_Mux), .ALU_Mux(ALU_Mux), .SE2_Ctrl(SE2_Ctrl), .CSRW_Mux(CSRW_Mux),
    .Branch_Mux(Branch_Mux), .flush_out(flush_out), .RByteEn_DM(RByteEn_DM),
    .WByteEn_DM(WByteEn_DM), .DM_Mux(DM_Mux), .WrEn_RF(WrEn_RF), .WD_Mux(WD_Mux),
    .wb_rd(wb_rd), .hazard_stall(hazard_stall)
`ifdef CTRL_FWD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       v;
    bit [6:0] op;
    bit [2:0] f3;
    bit [4:0] rd, rs1, rs2;
  } ins_t;

  // st[0]=EX, st[1..MS]=MEM, st[MS+1]=WB
  ins_t st [MS+2];
  bit [6:0] ops [10];
  int n_cmp = 0, n_bad = 0, cyc_n = 0;
  int cnt_haz = 0, cnt_flush = 0, cnt_pc = 0;
  bit m_take = 0;
  logic o_ready, o_pc, o_flush, o_se2, o_wren;
  logic [3:0] o_wbyte;
  logic [4:0] o_wbrd;
  logic [1:0] o_fa, o_fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic bit wr(ins_t i);
    return i.v && i.op != ST && i.op != BR;
  endfunction
  function automatic bit redirect(ins_t i, bit tk);
    return i.v && (i.op == AUIPC || i.op == JALR || i.op == JAL || (i.op == BR && tk));
  endfunction
  function automatic bit [1:0] alu(ins_t i);
    bit st_or_br;
    st_or_br = i.op == ST || i.op == BR;
    if (!i.v) return 2'b00;
    return {i.op == JALR || i.op == LD || i.op == OPI || st_or_br,
            (i.op == OPI && i.f3[1:0] == 2'b01) || st_or_br};
  endfunction
  function automatic bit [1:0] brm(ins_t i);
    if (!i.v) return 2'b00;
    return {i.op == JALR || i.op == LD || i.op == JAL, i.op == AUIPC || i.op == LUI || i.op == JAL};
  endfunction
  function automatic bit [3:0] wbe(ins_t i);
    if (!i.v || i.op != ST) return 4'h0;
    case (i.f3)
      3'd0:    return 4'h1;
      3'd1:    return 4'h3;
      3'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction
  function automatic bit [1:0] dmm(ins_t i);
    if (!i.v || i.op != LD) return 2'b00;
    return {!i.f3[1], i.f3 == 3'd2 || i.f3 == 3'd4 || i.f3 == 3'd5};
  endfunction
  function automatic bit producer(ins_t i, bit [4:0] r);
    return wr(i) && i.rd != 0 && i.rd == r;
  endfunction
  function automatic bit raw_stall(ins_t id);
    for (int k = 0; k < MS + 2; k++) begin
      if (producer(st[k], id.rs1) || producer(st[k], id.rs2)) begin
`ifdef CTRL_FWD_EN
        if (st[k].op == LD && k < MS) return 1'b1;
`else
        return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction
  function automatic bit [1:0] fwdsel(bit [4:0] r);
    if (!st[0].v) return 2'b00;
    if (producer(st[MS], r)) return 2'b01;
    if (producer(st[MS+1], r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < MS + 2; k++) st[k] = '0;
  endtask

  task automatic step();
    ins_t cur;
    bit e_flush, e_haz, e_ready;
    @(negedge clk);
    cyc_n++;
    if (rst) model_clear();
    cur.v = 1'b1; cur.op = id_opcode; cur.f3 = id_funct3;
    cur.rd = id_rd; cur.rs1 = id_rs1; cur.rs2 = id_rs2;
    e_flush = !stall_in && redirect(st[0], ex_take_branch);
    e_haz   = !rst && !stall_in && !e_flush && id_valid && raw_stall(cur);
    e_ready = !rst && !stall_in && !e_haz;
    o_ready = id_ready; o_pc = PC_Mux; o_flush = flush_out; o_se2 = SE2_Ctrl;
    o_wren = WrEn_RF; o_wbyte = WByteEn_DM; o_wbrd = wb_rd;
    chk("PC_Mux", 32'(PC_Mux), 32'(redirect(st[0], ex_take_branch)));
    chk("ALU_Mux", 32'(ALU_Mux), 32'(alu(st[0])));
    chk("SE2_Ctrl", 32'(SE2_Ctrl), 32'(st[0].v && st[0].op == BR));
    chk("CSRW_Mux", 32'(CSRW_Mux), 32'(st[0].v && st[0].op == SYS && st[0].f3[2]));
    chk("Branch_Mux", 32'(Branch_Mux), 32'(brm(st[0])));
    chk("RByteEn_DM", 32'(RByteEn_DM), st[MS].v ? 32'(st[MS].f3[1:0]) : 32'd0);
    chk("WByteEn_DM", 32'(WByteEn_DM), 32'(wbe(st[MS])));
    chk("DM_Mux", 32'(DM_Mux), 32'(dmm(st[MS])));
    chk("WrEn_RF", 32'(WrEn_RF), 32'(wr(st[MS+1])));
    chk("WD_Mux", 32'(WD_Mux), st[MS+1].v ? 32'({st[MS+1].op == AUIPC, st[MS+1].op == LUI}) : 32'd0);
    chk("wb_rd", 32'(wb_rd), st[MS+1].v ? 32'(st[MS+1].rd) : 32'd0);
    chk("flush_out", 32'(flush_out), 32'(e_flush));
    chk("hazard_stall", 32'(hazard_stall), 32'(e_haz));
    chk("id_ready", 32'(id_ready), 32'(e_ready));
`ifdef CTRL_FWD_EN
    o_fa = fwd_a; o_fb = fwd_b;
    chk("fwd_a", 32'(fwd_a), 32'(fwdsel(st[0].rs1)));
    chk("fwd_b", 32'(fwd_b), 32'(fwdsel(st[0].rs2)));
`endif
    cnt_haz   += int'(hazard_stall);
    cnt_flush += int'(flush_out);
    cnt_pc    += int'(PC_Mux);
    m_take = 1'b0;
    if (!rst && !stall_in) begin
      m_take = id_valid && e_ready;
      for (int k = MS + 1; k > 0; k--) st[k] = st[k-1];
      st[0] = (id_valid && !e_flush && !e_haz) ? cur : '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit [6:0] op, input bit [2:0] f3, input bit [4:0] rd,
                        input bit [4:0] rs1, input bit [4:0] rs2);
    id_opcode = op; id_funct3 = f3; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic issue(input bit [6:0] op, input bit [2:0] f3, input bit [4:0] rd,
                       input bit [4:0] rs1, input bit [4:0] rs2);
    set_id(op, f3, rd, rs1, rs2);
    id_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (o_ready) break;
    end
    chk("issue_accepted", 32'(o_ready), 32'd1);
    id_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tw, exp_lu, exp_raw;
    ops = '{LD, ST, BR, OPI, SYS, OPR, AUIPC, LUI, JALR, JAL};
    rst = 1'b1; id_valid = 1'b0; stall_in = 1'b0; ex_take_branch = 1'b0;
    set_id(7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    model_clear();
    step(); step();
    rst = 1'b0;

    // SW then SB: byte enables at the last MEM stage, no RF write at WB
    t0 = cyc_n;
    issue(ST, 3'd2, 5'd0, 5'd0, 5'd0);
    issue(ST, 3'd0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < MS + 3; k++) begin
      step();
      if (cyc_n == t0 + MS + 2) chk("sw_wbyte", 32'(o_wbyte), 32'hF);
      if (cyc_n == t0 + MS + 3) chk("sb_wbyte", 32'(o_wbyte), 32'h1);
      if (cyc_n == t0 + MS + 3 || cyc_n == t0 + MS + 4) chk("st_wb_wren", 32'(o_wren), 32'd0);
    end
    idle(MS + 2);

    // BEQ taken in EX squashes the ID instruction
    issue(BR, 3'd0, 5'd0, 5'd0, 5'd0);
    set_id(OPI, 3'd0, 5'd1, 5'd0, 5'd0);
    id_valid = 1'b1; ex_take_branch = 1'b1;
    step();
    chk("beq_pc_mux", 32'(o_pc), 32'd1);
    chk("beq_flush", 32'(o_flush), 32'd1);
    chk("beq_se2", 32'(o_se2), 32'd1);
    id_valid = 1'b0;
    step();
    chk("beq_flush_pulse", 32'(o_flush), 32'd0);
    chk("beq_bubble_pc", 32'(o_pc), 32'd0);
    chk("beq_bubble_se2", 32'(o_se2), 32'd0);
    ex_take_branch = 1'b0;
    idle(MS + 2);

    // LW x5 ; ADD x6,x5,x1
`ifdef CTRL_FWD_EN
    exp_lu = MS; exp_raw = 0;
`else
    exp_lu = MS + 2; exp_raw = MS + 2;
`endif
    t0 = cyc_n;
    issue(LD, 3'd2, 5'd5, 5'd0, 5'd0);
    cnt_haz = 0;
    issue(OPR, 3'd0, 5'd6, 5'd5, 5'd1);
    chk("lu_stall_cycles", 32'(cnt_haz), 32'(exp_lu));
    tw = -1;
    for (int n = 0; n < 12 && tw < 0; n++) begin
      step();
      if (o_wren && o_wbrd == 5'd6) tw = cyc_n;
    end
    chk("lu_add_wb_cycle", 32'(tw - t0), 32'(MS + 4 + exp_lu));
    idle(MS + 2);

    // same sequence with rd=x0
    issue(LD, 3'd2, 5'd0, 5'd0, 5'd0);
    cnt_haz = 0;
    issue(OPR, 3'd0, 5'd6, 5'd0, 5'd1);
    chk("x0_no_stall", 32'(cnt_haz), 32'd0);
    idle(MS + 2);

    // ADD x3 ; SUB x4,x3,x3
    issue(OPR, 3'd0, 5'd3, 5'd0, 5'd0);
    cnt_haz = 0;
    issue(OPR, 3'd0, 5'd4, 5'd3, 5'd3);
    chk("raw_stall_cycles", 32'(cnt_haz), 32'(exp_raw));
    step();
`ifdef CTRL_FWD_EN
    chk("sub_fwd_a", 32'(o_fa), 32'd1);
    chk("sub_fwd_b", 32'(o_fb), 32'd1);
`endif
    idle(MS + 2);

    // external stall with three in flight and a redirect waiting in EX
    issue(OPI, 3'd0, 5'd1, 5'd0, 5'd0);
    issue(OPI, 3'd0, 5'd2, 5'd0, 5'd0);
    issue(JAL, 3'd0, 5'd3, 5'd0, 5'd0);
    set_id(OPI, 3'd0, 5'd4, 5'd0, 5'd0);
    id_valid = 1'b1; stall_in = 1'b1;
    cnt_pc = 0; cnt_flush = 0;
    repeat (3) step();
    chk("stall_pc_held", 32'(cnt_pc), 32'd3);
    chk("stall_no_flush", 32'(cnt_flush), 32'd0);
    stall_in = 1'b0;
    step();
    chk("resume_flush", 32'(o_flush), 32'd1);
    idle(MS + 2);

    // asynchronous reset while WB writes the RF
    issue(OPI, 3'd0, 5'd7, 5'd0, 5'd0);
    idle(MS + 1);
    #2;
    chk("pre_rst_wren", 32'(WrEn_RF), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_wren", 32'(WrEn_RF), 32'd0);
    chk("async_rst_all", 32'({PC_Mux, ALU_Mux, SE2_Ctrl, CSRW_Mux, Branch_Mux, flush_out,
                              RByteEn_DM, WByteEn_DM, DM_Mux, WrEn_RF, WD_Mux, wb_rd,
                              hazard_stall, id_ready}), 32'd0);
    model_clear();
    step();
    rst = 1'b0;
    issue(OPI, 3'd0, 5'd1, 5'd0, 5'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (!(id_valid && !m_take)) begin
        id_valid = ($urandom_range(0, 3) != 0);
        set_id(($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)],
               3'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)));
      end
      stall_in       = ($urandom_range(0, 7) == 0);
      ex_take_branch = 1'($urandom);
      rst            = ($urandom_range(0, 127) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the single-stage RV32I control decoder.
- Decodes opcode/funct3 in ID and carries the resulting control bundle through an EX register, a parametrised MEM register chain and a WB register, with a valid bit per stage.
- Adds handshake-based stalling, branch/jump flush and load-use hazard detection.
- Sits between the instruction fetch/decode path and the datapath muxes, RF and data cache.

Parameters:
- MEM_STAGES, 1, number of MEM register stages (>=1); models multicycle data-cache latency.
- RF_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_ready  out  1  ctrl_pipe accepts the ID instruction this cycle.
- id_opcode  in  7  instruction[6:0].
- id_funct3  in  3  instruction[14:12].
- id_rd, id_rs1, id_rs2  in  RF_ADDR_W  register addresses.
- stall_in  in  1  external freeze, e.g. cache miss.
- ex_take_branch  in  1  branch comparator result for the instruction in EX.
- PC_Mux  out  1  EX-stage redirect.
- ALU_Mux  out  2  EX-stage ALU select.
- SE2_Ctrl  out  1  EX-stage select.
- CSRW_Mux  out  1  EX-stage select.
- Branch_Mux  out  2  EX-stage select.
- flush_out  out  1  one-cycle pulse when a redirect squashes ID.
- RByteEn_DM  out  2  from last MEM stage.
- WByteEn_DM  out  4  from last MEM stage.
- DM_Mux  out  2  from last MEM stage.
- WrEn_RF  out  1  from WB stage.
- WD_Mux  out  2  from WB stage.
- wb_rd  out  RF_ADDR_W  from WB stage.
- hazard_stall  out  1  load-use bubble inserted this cycle.
- fwd_a, fwd_b  out  2  forwarding selects; present only with CTRL_FWD_EN.

Behaviour:
- Decode equations, evaluated on ID fields and registered into EX. Opcodes: LD=0000011, ST=0100011, BR=1100011, OPI=0010011, SYS=1110011.
  - PC_Mux = opcode==0010111 | opcode==110x111 | (BR & ex_take_branch). Combinational in EX.
  - WrEn_RF = !BR & !ST.
  - WD_Mux = {opcode==0010111, opcode==0110111}.
  - DM_Mux[0] = LD & (funct3==010 | funct3[2:1]==10).
  - DM_Mux[1] = LD & !funct3[1].
  - Branch_Mux[0] = opcode==0x10111 | opcode==1101111.
  - Branch_Mux[1] = opcode==1100111 | LD | opcode==1101111.
  - CSRW_Mux = SYS & funct3[2].
  - SE2_Ctrl = BR.
  - RByteEn_DM = funct3[1:0].
  - ALU_Mux[0] = (OPI & funct3[1:0]==01) | opcode[5:0]==100011.
  - ALU_Mux[1] = opcode==1100111 | LD | OPI | opcode[5:0]==100011.
  - WByteEn_DM: ST with funct3 0/1/2 -> 0001/0011/1111; any other funct3 or non-store -> 0000. No latch on WByteEn_DM.
- Valid gating: outputs of an invalid stage are forced to 0. This covers PC_Mux, WrEn_RF, WByteEn_DM, and all other control outputs.
- Latency: ID->EX 1 cycle; EX->last MEM MEM_STAGES cycles; ->WB 1 more. Total 2+MEM_STAGES cycles.
- id_ready = !stall_in & !hazard_stall.
- Priority, highest first: rst > stall_in > flush > hazard > normal advance.
- stall_in=1: every stage register holds, including valid bits. flush_out and hazard_stall are 0. PC_Mux still reflects EX.
- Flush: EX valid & PC_Mux & !stall_in.
  - The ID instruction is discarded and a bubble (valid=0) enters EX next cycle.
  - The EX instruction advances normally.
  - flush_out=1 for that cycle.
- Load-use hazard: EX valid & LD & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2) & no flush.
  - hazard_stall=1 and id_ready=0.
  - Bubble into EX; ID not consumed.
  - Resolves after exactly one bubble when MEM_STAGES=1. Otherwise the check extends to every MEM stage except the last.
- rd==0 never triggers a hazard or forward.
- Reset, including mid-operation: all valid bits cleared, all stage registers zeroed, all outputs 0. The first instruction is accepted the cycle after rst deasserts.

Optional Feature:
- Macro CTRL_FWD_EN.
- Defined:
  - fwd_a/fwd_b are generated combinationally for the EX instruction: 01 = forward from the last MEM stage, 10 = forward from WB, 00 = RF.
  - Nearest producer wins. Only valid producers with WrEn_RF=1 and rd!=0 are considered.
  - Hazard detection covers load-use only.
- Undefined:
  - Ports fwd_a/fwd_b are absent.
  - Hazard detection stalls ID on any RAW match against any valid in-flight rd with WrEn_RF=1, not just loads, until the producer leaves WB.

Test Plan:
- SW (opcode 0100011, funct3 010), then SB (funct3 000), MEM_STAGES=1 -> WByteEn_DM=1111 two cycles after acceptance, then 0001; WrEn_RF=0 at WB for both.
- BEQ in EX with ex_take_branch=1 -> PC_Mux=1, flush_out=1 for one cycle, next EX valid=0, SE2_Ctrl=1 during the BEQ's EX cycle.
- LW x5 then ADD x6,x5,x1 -> hazard_stall=1 and id_ready=0 for exactly 1 cycle; ADD reaches WB one cycle later than without the dependency. The same sequence with rd=x0 -> no stall.
- stall_in held high for 3 cycles with 3 instructions in flight -> all outputs frozen; then resume with no loss or duplication; flush suppressed while stalled.
- rst asserted asynchronously mid-stream with WrEn_RF=1 at WB -> WrEn_RF=0 and all outputs 0 immediately, without waiting for a clock edge.
- CTRL_FWD_EN, ADD x3 then SUB x4,x3,x3 -> fwd_a=fwd_b=01 in SUB's EX cycle, no stall. Without the macro -> stall until ADD leaves WB.
